// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-port memory arbiter.
//   port_e      : requester identity (I-port = instruction fetch, D-port =
//                 load/store). The encoding doubles as the bit index of that
//                 requester in the req/gnt vectors.
//   arb_state_e : response tracker state.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    // Maps a one-hot grant vector to the winning port. Only meaningful when
    // some bit of gnt is set; an empty vector maps to PORT_I.
    function automatic port_e gnt_to_port(input logic [1:0] gnt);
        return gnt[1] ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
// Ports:
//   req[1:0]    in   request vector, bit 0 = I-port, bit 1 = D-port
//   last_grant  in   port granted most recently
//   gnt[1:0]    out  one-hot grant (all zero when nothing requests)
// A lone requester always wins; on contention the port that did not win
// last time gets the grant.
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, 1-cycle-read-latency memory between the
// instruction-fetch requester (I-port, read only) and the load/store
// requester (D-port, read/write). At most one access is granted per cycle,
// with round-robin fairness under contention, and read data is routed back
// to whichever port issued the access.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_req_valid_i / i_addr_i        I-port read request
//   i_req_ready_o                   I-port accepted this cycle
//   i_rsp_valid_o / i_rsp_data_o    I-port read response
//   d_req_valid_i / d_we_i          D-port request, 1 = write
//   d_addr_i / d_wdata_i            D-port address / write data
//   d_req_ready_o                   D-port accepted this cycle
//   d_rsp_valid_o / d_rsp_data_o    D-port response (data 0 on write ack)
//   mem_addr_o / mem_data_o         memory address / write data
//   mem_read_en_o / mem_write_en_o  memory strobes
//   mem_data_i                      memory read data, valid cycle after read
//
// Response tracker FSM:
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no access was granted last cycle, no response due
//   RESP  | access granted last cycle; respond to rsp_owner_q this cycle
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_req_ready_o,
    output logic              i_rsp_valid_o,
    output logic [DWIDTH-1:0] i_rsp_data_o,

    input  logic              d_req_valid_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_req_ready_o,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rsp_data_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    logic [1:0] req;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       grant_any;
    port_e      grant_port;
    logic       grant_is_wr;

    arb_state_e state_q;
    arb_state_e state_d;
    port_e      last_grant_q;
    port_e      rsp_owner_q;
    logic       rsp_is_wr_q;
    logic       rsp_live;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req = {d_req_valid_i, i_req_valid_i};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt_raw)
    );

    // Nothing is granted while reset is held, so readys and memory strobes
    // stay quiet regardless of what the requesters present.
    assign gnt         = rst ? 2'b00 : gnt_raw;
    assign grant_any   = |gnt;
    assign grant_port  = gnt_to_port(gnt);
    assign grant_is_wr = gnt[PORT_D] & d_we_i;

    assign i_req_ready_o = gnt[PORT_I];
    assign d_req_ready_o = gnt[PORT_D];

    // ------------------------------------------------------------------
    // Memory request path, driven straight from the winner
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (gnt[PORT_I]) begin
            mem_addr_o    = i_addr_i;
            mem_read_en_o = 1'b1;
        end else if (gnt[PORT_D]) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_data_o     = d_wdata_i;
                mem_write_en_o = 1'b1;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            rsp_owner_q  <= PORT_I;
            rsp_is_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                last_grant_q <= grant_port;
                rsp_owner_q  <= grant_port;
                rsp_is_wr_q  <= grant_is_wr;
            end
        end
    end

    // A grant in RESP keeps us in RESP, which is what sustains one access
    // per cycle: the current response and the next grant share a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_any ? RESP : IDLE;
            RESP:    state_d = grant_any ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst drops a response that was due in the cycle reset
    // arrives, so a reset taken in RESP never leaks a stale pulse.
    assign rsp_live = (state_q == RESP) && !rst;

    assign i_rsp_valid_o = rsp_live && (rsp_owner_q == PORT_I);
    assign d_rsp_valid_o = rsp_live && (rsp_owner_q == PORT_D);

    // Memory read data is only valid in the response cycle, so it is
    // steered combinationally rather than re-registered; the select terms
    // come from flops, keeping the outputs at 0 out of reset.
    assign i_rsp_data_o = (i_rsp_valid_o && !rsp_is_wr_q) ? mem_data_i : '0;
    assign d_rsp_data_o = (d_rsp_valid_o && !rsp_is_wr_q) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          i_req_valid;
    logic [AW-1:0] i_addr;
    logic          i_req_ready;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid_i  (i_req_valid),
        .i_addr_i       (i_addr),
        .i_req_ready_o  (i_req_ready),
        .i_rsp_valid_o  (i_rsp_valid),
        .i_rsp_data_o   (i_rsp_data),
        .d_req_valid_i  (d_req_valid),
        .d_we_i         (d_we),
        .d_addr_i       (d_addr),
        .d_wdata_i      (d_wdata),
        .d_req_ready_o  (d_req_ready),
        .d_rsp_valid_o  (d_rsp_valid),
        .d_rsp_data_o   (d_rsp_data),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_read_en_o  (mem_read_en),
        .mem_write_en_o (mem_write_en),
        .mem_data_i     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory, 64 words, 1-cycle read latency.
    logic [DW-1:0] mem_arr [0:63];
    always @(posedge clk) begin
        if (mem_write_en) mem_arr[mem_addr[7:2]] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem_arr[mem_addr[7:2]];
    end

    // Reference contents used to form expected read data.
    logic [DW-1:0] ref_mem [0:63];

    typedef struct packed {
        logic          iv;
        logic          dv;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readys/memory strobes and the
    // response due from the previous cycle's grant, then queue the response
    // this cycle's expected grant should produce.
    task automatic step(input logic rst_v,
                        input logic iv, input logic [31:0] ia,
                        input logic dv, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic ei, input logic ed,
                        input string tag);
        exp_t e;
        exp_t n;
        logic [31:0] exp_addr;
        rst         = rst_v;
        i_req_valid = iv;
        i_addr      = ia;
        d_req_valid = dv;
        d_we        = dwe;
        d_addr      = da;
        d_wdata     = dwd;
        @(negedge clk);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (rst_v) begin
            e = '0;
            sb.delete();
        end
        exp_addr = ei ? ia : (ed ? da : 32'h0);
        chk({tag, "/i_ready"}, {31'b0, i_req_ready}, {31'b0, ei});
        chk({tag, "/d_ready"}, {31'b0, d_req_ready}, {31'b0, ed});
        chk({tag, "/rd_en"}, {31'b0, mem_read_en}, {31'b0, ei | (ed & ~dwe)});
        chk({tag, "/wr_en"}, {31'b0, mem_write_en}, {31'b0, ed & dwe});
        chk({tag, "/mem_addr"}, mem_addr, exp_addr);
        if ((ed && dwe) || (!ei && !ed))
            chk({tag, "/mem_wdata"}, mem_wdata, (ed && dwe) ? dwd : 32'h0);
        chk({tag, "/i_rsp_valid"}, {31'b0, i_rsp_valid}, {31'b0, e.iv});
        chk({tag, "/d_rsp_valid"}, {31'b0, d_rsp_valid}, {31'b0, e.dv});
        if (e.iv) chk({tag, "/i_rsp_data"}, i_rsp_data, e.data);
        if (e.dv) chk({tag, "/d_rsp_data"}, d_rsp_data, e.data);
        if (!rst_v) begin
            n = '0;
            if (ei) begin
                n.iv   = 1'b1;
                n.data = ref_mem[ia[7:2]];
            end else if (ed) begin
                n.dv = 1'b1;
                if (dwe) begin
                    n.data = 32'h0;
                    ref_mem[da[7:2]] = dwd;
                end else begin
                    n.data = ref_mem[da[7:2]];
                end
            end
            sb.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 64; k++) begin
            mem_arr[k] = 32'hA500_0000 | k;
            ref_mem[k] = 32'hA500_0000 | k;
        end
        mem_arr[0] = 32'h1111_0000;  ref_mem[0] = 32'h1111_0000;
        mem_arr[1] = 32'h2222_0004;  ref_mem[1] = 32'h2222_0004;
        mem_arr[2] = 32'h3333_0008;  ref_mem[2] = 32'h3333_0008;
        mem_arr[4] = 32'h0051_3023;  ref_mem[4] = 32'h0051_3023;
        mem_rdata   = '0;
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_addr      = '0;
        d_req_valid = 1'b0;
        d_we        = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;

        // Reset held 3 cycles with both requesters valid: everything quiet.
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "reset");
        chk("reset/state", {31'b0, dut.state_q}, {31'b0, IDLE});

        // Continuous contention: I wins first, then strict alternation.
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0,
                 (k % 2) == 0, (k % 2) == 1, "contention");
        idle("contention_drain");

        // Single I read.
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "i_read");
        idle("i_read_rsp");

        // D write, then I read of the same address; the write ack and the
        // read grant share a cycle.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b1, "d_write");
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "i_read_after_wr");
        idle("i_read_after_wr_rsp");

        // Back-to-back D reads with no bubbles.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "d_b2b_0");
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, "d_b2b_4");
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, "d_b2b_8");
        idle("d_b2b_drain");

        // Reset arriving in the response cycle of a D read drops it.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, "mid_rst_grant");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "mid_rst_0");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "mid_rst_1");
        chk("mid_rst/state", {31'b0, dut.state_q}, {31'b0, IDLE});
        idle("post_rst_0");
        idle("post_rst_1");

        // last_grant is back to D, so I wins the first contention again.
        step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, "post_rst_cont_i");
        step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, "post_rst_cont_d");
        idle("post_rst_drain");
        chk("final/state", {31'b0, dut.state_q}, {31'b0, IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
